// File: rtl/warp_pkg.sv
// rtl/warp_pkg.sv - shared widths and per-warp lifecycle state for the warp status tracker
package warp_pkg;

  localparam int NUM_WARPS    = 16;
  localparam int WARPID_DEPTH = $clog2(NUM_WARPS);
  localparam int MAX_PENDING  = 4;
  localparam int PEND_DEPTH   = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BARRIER = 2'd2,
    EXITING = 2'd3
  } warp_state_t;

endpackage

// File: rtl/warp_state_table_if.sv
// rtl/warp_state_table_if.sv - launch/issue/writeback inputs and ready/status outputs of the warp tracker
interface warp_state_table_if;
  import warp_pkg::*;

  logic                    launch_valid;
  logic [NUM_WARPS-1:0]    launch_mask;
  logic                    issue_valid;
  logic [WARPID_DEPTH-1:0] issue_warp;
  logic                    issue_barrier;
  logic                    issue_exit;
  logic                    wb_valid;
  logic [WARPID_DEPTH-1:0] wb_warp;
  logic [NUM_WARPS-1:0]    ready;
  logic [NUM_WARPS-1:0]    active;
  logic                    all_done;
  logic                    barrier_release;
  logic                    err;

  modport master (
    output launch_valid, launch_mask, issue_valid, issue_warp, issue_barrier, issue_exit,
           wb_valid, wb_warp,
    input  ready, active, all_done, barrier_release, err
  );

  modport slave (
    input  launch_valid, launch_mask, issue_valid, issue_warp, issue_barrier, issue_exit,
           wb_valid, wb_warp,
    output ready, active, all_done, barrier_release, err
  );

endinterface

// File: rtl/warp_state_entry.sv
// rtl/warp_state_entry.sv - one warp's lifecycle state, in-flight counter and protocol error strobe
module warp_state_entry
  import warp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_hit,
  input  logic        issue_hit,
  input  logic        issue_barrier,
  input  logic        issue_exit,
  input  logic        wb_hit,
  input  logic        release_hit,
  output warp_state_t state,
  output logic        ready,
  output logic        err_strobe
);

  warp_state_t           state_next;
  logic [PEND_DEPTH-1:0] pending;
  logic [PEND_DEPTH-1:0] pending_next;
  logic                  issue_ok;
  logic                  wb_ok;

  assign ready    = (state == ACTIVE) && (pending < PEND_DEPTH'(MAX_PENDING));
  assign issue_ok = issue_hit && ready;
  assign wb_ok    = wb_hit && (pending != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    err_strobe   = 1'b0;

    // A simultaneous legal issue and retire cancel out on the counter.
    if (issue_ok && !wb_ok) begin
      pending_next = pending + 1'b1;
    end else if (wb_ok && !issue_ok) begin
      pending_next = pending - 1'b1;
    end

    if (issue_hit && !ready)                     err_strobe = 1'b1;
    if (wb_hit && (pending == '0))               err_strobe = 1'b1;
    if (issue_ok && issue_barrier && issue_exit) err_strobe = 1'b1;
    if (launch_hit && (state != IDLE))           err_strobe = 1'b1;

    unique case (state)
      IDLE: begin
        if (launch_hit) begin
          state_next   = ACTIVE;
          pending_next = '0;
        end
      end
      ACTIVE: begin
        if (issue_ok && issue_exit) begin
          state_next = EXITING;
        end else if (issue_ok && issue_barrier) begin
          state_next = BARRIER;
        end
      end
      BARRIER: begin
        if (release_hit) state_next = ACTIVE;
      end
      EXITING: begin
        if (pending_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/warp_state_table.sv
// rtl/warp_state_table.sv - per-warp status tracker producing the scheduler ready vector
module warp_state_table
  import warp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  warp_state_table_if.slave   bus
);

  logic [NUM_WARPS-1:0] launch_hit;
  logic [NUM_WARPS-1:0] issue_dec;
  logic [NUM_WARPS-1:0] wb_dec;
  logic [NUM_WARPS-1:0] ready_vec;
  logic [NUM_WARPS-1:0] active_vec;
  logic [NUM_WARPS-1:0] is_active;
  logic [NUM_WARPS-1:0] is_barrier;
  logic [NUM_WARPS-1:0] err_vec;
  logic                 release_hit;
  logic                 barrier_release_q;
  logic                 err_q;
  warp_state_t          state_w [NUM_WARPS];

  assign launch_hit = bus.launch_valid ? bus.launch_mask : '0;

  always_comb begin
    issue_dec = '0;
    wb_dec    = '0;
    if (bus.issue_valid) issue_dec[bus.issue_warp] = 1'b1;
    if (bus.wb_valid)    wb_dec[bus.wb_warp]       = 1'b1;
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_entry
    warp_state_entry u_entry (
      .clk           (clk),
      .rst           (rst),
      .launch_hit    (launch_hit[w]),
      .issue_hit     (issue_dec[w]),
      .issue_barrier (bus.issue_barrier),
      .issue_exit    (bus.issue_exit),
      .wb_hit        (wb_dec[w]),
      .release_hit   (release_hit),
      .state         (state_w[w]),
      .ready         (ready_vec[w]),
      .err_strobe    (err_vec[w])
    );
    assign is_active[w]  = (state_w[w] == ACTIVE);
    assign is_barrier[w] = (state_w[w] == BARRIER);
    assign active_vec[w] = (state_w[w] != IDLE);
  end

  // Only warps still able to reach the barrier hold it back; EXITING/IDLE never will.
  assign release_hit = ~|is_active && |is_barrier;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      barrier_release_q <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      barrier_release_q <= release_hit;
      err_q             <= err_q | (|err_vec);
    end
  end

  assign bus.ready           = ready_vec;
  assign bus.active          = active_vec;
  assign bus.all_done        = ~|active_vec;
  assign bus.barrier_release = barrier_release_q;
  assign bus.err             = err_q;

endmodule

// File: tb/tb_warp_state_table.sv
// tb/tb_warp_state_table.sv - directed self-checking bench for warp_state_table
module tb_warp_state_table;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  warp_state_table_if bus ();

  warp_state_table dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.launch_valid  = 1'b0;
    bus.launch_mask   = '0;
    bus.issue_valid   = 1'b0;
    bus.issue_warp    = '0;
    bus.issue_barrier = 1'b0;
    bus.issue_exit    = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_warp       = '0;
  endtask

  task automatic cyc(input logic lv, input logic [15:0] lm, input logic iv, input logic [3:0] iw,
                     input logic ib, input logic ie, input logic wv, input logic [3:0] ww);
    bus.launch_valid  = lv;
    bus.launch_mask   = lm;
    bus.issue_valid   = iv;
    bus.issue_warp    = iw;
    bus.issue_barrier = ib;
    bus.issue_exit    = ie;
    bus.wb_valid      = wv;
    bus.wb_warp       = ww;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic launch(input logic [15:0] m);
    cyc(1'b1, m, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic issue(input logic [3:0] w, input logic b, input logic e);
    cyc(1'b0, 16'h0, 1'b1, w, b, e, 1'b0, 4'd0);
  endtask

  task automatic wb(input logic [3:0] w);
    cyc(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, w);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",    32'(bus.ready), 32'h0000);
    chk("rst_active",   32'(bus.active), 32'h0000);
    chk("rst_all_done", 32'(bus.all_done), 32'h1);
    chk("rst_brel",     32'(bus.barrier_release), 32'h0);
    chk("rst_err",      32'(bus.err), 32'h0);
    rst = 1'b0;

    launch(16'h0005);
    chk("launch_active",   32'(bus.active), 32'h0005);
    chk("launch_ready",    32'(bus.ready), 32'h0005);
    chk("launch_all_done", 32'(bus.all_done), 32'h0);

    issue(4'd0, 1'b0, 1'b0);
    issue(4'd0, 1'b0, 1'b0);
    issue(4'd0, 1'b0, 1'b0);
    chk("pend3_ready", 32'(bus.ready), 32'h0005);
    issue(4'd0, 1'b0, 1'b0);
    chk("pend4_ready", 32'(bus.ready), 32'h0004);
    wb(4'd0);
    chk("wb_ready", 32'(bus.ready), 32'h0005);
    cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("iss_wb_ready", 32'(bus.ready), 32'h0005);
    issue(4'd0, 1'b0, 1'b0);
    chk("iss_wb_pend4", 32'(bus.ready), 32'h0004);
    repeat (4) wb(4'd0);
    chk("drain_ready", 32'(bus.ready), 32'h0005);
    chk("drain_err",   32'(bus.err), 32'h0);

    issue(4'd0, 1'b1, 1'b0);
    chk("bar0_ready",  32'(bus.ready), 32'h0004);
    chk("bar0_active", 32'(bus.active), 32'h0005);
    issue(4'd2, 1'b1, 1'b0);
    chk("bar2_ready", 32'(bus.ready), 32'h0000);
    chk("bar2_brel",  32'(bus.barrier_release), 32'h0);
    idle();
    chk("rel_ready", 32'(bus.ready), 32'h0005);
    chk("rel_brel",  32'(bus.barrier_release), 32'h1);
    idle();
    chk("rel_brel_off", 32'(bus.barrier_release), 32'h0);

    issue(4'd2, 1'b0, 1'b1);
    chk("exit2_ready",  32'(bus.ready), 32'h0001);
    chk("exit2_active", 32'(bus.active), 32'h0005);
    wb(4'd2);
    chk("exit2_wb1_active", 32'(bus.active), 32'h0005);
    wb(4'd2);
    chk("exit2_wb2_active", 32'(bus.active), 32'h0001);
    issue(4'd0, 1'b0, 1'b1);
    chk("exit0_ready",    32'(bus.ready), 32'h0000);
    chk("exit0_all_done", 32'(bus.all_done), 32'h0);
    wb(4'd0);
    chk("exit0_wb1_active", 32'(bus.active), 32'h0001);
    wb(4'd0);
    chk("exit0_active",   32'(bus.active), 32'h0000);
    chk("exit0_all_done2", 32'(bus.all_done), 32'h1);
    chk("exit0_err",      32'(bus.err), 32'h0);

    launch(16'h0003);
    issue(4'd0, 1'b0, 1'b1);
    issue(4'd1, 1'b1, 1'b0);
    chk("exbar_ready", 32'(bus.ready), 32'h0000);
    idle();
    chk("exbar_rel_ready", 32'(bus.ready), 32'h0002);
    chk("exbar_rel_brel",  32'(bus.barrier_release), 32'h1);
    chk("exbar_active",    32'(bus.active), 32'h0003);
    wb(4'd0);
    chk("exbar_wb_active", 32'(bus.active), 32'h0002);

    do_reset();
    launch(16'h0001);
    issue(4'd5, 1'b0, 1'b0);
    chk("e_iss_err",    32'(bus.err), 32'h1);
    chk("e_iss_ready",  32'(bus.ready), 32'h0001);
    chk("e_iss_active", 32'(bus.active), 32'h0001);

    do_reset();
    launch(16'h0001);
    wb(4'd7);
    chk("e_wb_err",    32'(bus.err), 32'h1);
    chk("e_wb_active", 32'(bus.active), 32'h0001);
    chk("e_wb_ready",  32'(bus.ready), 32'h0001);

    do_reset();
    launch(16'h0001);
    issue(4'd0, 1'b0, 1'b0);
    launch(16'h0001);
    chk("e_rel_err",    32'(bus.err), 32'h1);
    chk("e_rel_active", 32'(bus.active), 32'h0001);
    issue(4'd0, 1'b0, 1'b0);
    issue(4'd0, 1'b0, 1'b0);
    issue(4'd0, 1'b0, 1'b0);
    chk("e_rel_pend_kept", 32'(bus.ready), 32'h0000);

    do_reset();
    launch(16'h0001);
    issue(4'd0, 1'b1, 1'b1);
    chk("e_be_err",    32'(bus.err), 32'h1);
    chk("e_be_ready",  32'(bus.ready), 32'h0000);
    chk("e_be_active", 32'(bus.active), 32'h0001);
    idle();
    chk("e_be_no_rel", 32'(bus.barrier_release), 32'h0);
    wb(4'd0);
    chk("e_be_exit_active", 32'(bus.active), 32'h0000);
    chk("e_be_err_sticky",  32'(bus.err), 32'h1);

    do_reset();
    launch(16'h0003);
    issue(4'd0, 1'b1, 1'b0);
    wb(4'd7);
    issue(4'd1, 1'b0, 1'b0);
    chk("pre_rst_ready", 32'(bus.ready), 32'h0002);
    chk("pre_rst_err",   32'(bus.err), 32'h1);
    bus.issue_valid = 1'b1;
    bus.issue_warp  = 4'd1;
    bus.wb_valid    = 1'b1;
    bus.wb_warp     = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_ready",    32'(bus.ready), 32'h0000);
    chk("async_active",   32'(bus.active), 32'h0000);
    chk("async_all_done", 32'(bus.all_done), 32'h1);
    chk("async_err",      32'(bus.err), 32'h0);
    chk("async_brel",     32'(bus.barrier_release), 32'h0);
    @(posedge clk);
    #1;
    chk("hold_active", 32'(bus.active), 32'h0000);
    idle_inputs();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
